// File: rtl/layer_compositor_pkg.sv
// Shared constants for the layer compositor: background index and the
// reset values of the layer-enable and blink registers.
package compositor_pkg;

    localparam int              MAX_LAYERS  = 8;
    localparam int              FRAME_CNT_W = 8;

    // hitLayer value reported when no layer wins (background or blanking)
    localparam logic [2:0]            BG_INDEX    = 3'd7;

    // All layers enabled and no layer blinking out of reset
    localparam logic [MAX_LAYERS-1:0] MASK_RESET  = '1;
    localparam logic [MAX_LAYERS-1:0] BLINK_RESET = '0;

endpackage

// File: rtl/layer_compositor_if.sv
// Pixel/config bundle for the layer compositor.
// Handshake: there is no back-pressure. The source presents one pixel per
// clock qualified by displayEnable; the compositor returns it two clocks later
// qualified by colorValid. frameStart and cfgWrite are single-cycle strobes.
interface layer_compositor_if #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 8
);
    logic                          displayEnable;
    logic                          frameStart;
    logic [NUM_LAYERS*COLOR_W-1:0] layerColor;
    logic [NUM_LAYERS-1:0]         layerShow;
    logic [NUM_LAYERS-1:0]         maskIn;
    logic [NUM_LAYERS-1:0]         blinkIn;
    logic                          cfgWrite;
    logic [COLOR_W-1:0]            bgColor;

    logic [COLOR_W-1:0]            color;
    logic                          colorValid;
    logic [2:0]                    hitLayer;
    logic [NUM_LAYERS-1:0]         overlapMask;

    // Pixel source / configuration side
    modport master (
        output displayEnable, frameStart, layerColor, layerShow,
               maskIn, blinkIn, cfgWrite, bgColor,
        input  color, colorValid, hitLayer, overlapMask
    );

    // Compositor side
    modport slave (
        input  displayEnable, frameStart, layerColor, layerShow,
               maskIn, blinkIn, cfgWrite, bgColor,
        output color, colorValid, hitLayer, overlapMask
    );
endinterface

// File: rtl/layer_compositor_priority_select.sv
// Combinational lowest-index layer select plus multi-layer overlap detect.
module priority_select
    import compositor_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 8
) (
    input  logic [NUM_LAYERS-1:0]         i_show,
    input  logic [NUM_LAYERS*COLOR_W-1:0] i_colors,
    output logic [2:0]                    o_index,
    output logic [COLOR_W-1:0]            o_color,
    output logic                          o_any,
    output logic                          o_overlap
);

    // Walk from the highest index down so layer 0 overrides everything
    always_comb begin
        o_index = BG_INDEX;
        o_color = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (i_show[i]) begin
                o_index = 3'(i);
                o_color = i_colors[i*COLOR_W +: COLOR_W];
            end
        end
        o_any     = |i_show;
        // Clearing the lowest set bit leaves something only if 2+ bits were set
        o_overlap = |(i_show & (i_show - NUM_LAYERS'(1)));
    end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage priority compositor: stage 1 qualifies layers with the
// frame-synchronous mask and blink gate, stage 2 picks the winning colour.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int NUM_LAYERS   = 4,
    parameter int COLOR_W      = 8,
    parameter int BLINK_FRAMES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    layer_compositor_if.slave  bus
);

    localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(BLINK_FRAMES - 1);

    logic [NUM_LAYERS-1:0]         r_shadow_mask;
    logic [NUM_LAYERS-1:0]         r_shadow_blink;
    logic [NUM_LAYERS-1:0]         r_active_mask;
    logic [NUM_LAYERS-1:0]         r_active_blink;
    logic                          r_frame_start_d;
    logic [FRAME_CNT_W-1:0]        r_frame_cnt;
    logic                          r_blink_phase;

    logic [NUM_LAYERS*COLOR_W-1:0] r_s1_color;
    logic [NUM_LAYERS-1:0]         r_s1_show;
    logic                          r_s1_de;
    logic [COLOR_W-1:0]            r_s1_bg;

    logic [COLOR_W-1:0]            r_color;
    logic                          r_valid;
    logic [2:0]                    r_hit;
    logic [NUM_LAYERS-1:0]         r_overlap;

    logic [NUM_LAYERS-1:0]         w_blink_gate;
    logic [2:0]                    w_sel_index;
    logic [COLOR_W-1:0]            w_sel_color;
    logic                          w_sel_any;
    logic                          w_sel_overlap;

    // A blinking layer is only visible during the "on" phase
    assign w_blink_gate = ~r_active_blink | {NUM_LAYERS{r_blink_phase}};

    // Shadow config captures on cfgWrite; active copy swaps in one cycle after
    // frameStart so a same-cycle cfgWrite still reaches the new frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow_mask   <= MASK_RESET[NUM_LAYERS-1:0];
            r_shadow_blink  <= BLINK_RESET[NUM_LAYERS-1:0];
            r_active_mask   <= MASK_RESET[NUM_LAYERS-1:0];
            r_active_blink  <= BLINK_RESET[NUM_LAYERS-1:0];
            r_frame_start_d <= 1'b0;
        end else begin
            if (bus.cfgWrite) begin
                r_shadow_mask  <= bus.maskIn;
                r_shadow_blink <= bus.blinkIn;
            end
            r_frame_start_d <= bus.frameStart;
            if (r_frame_start_d) begin
                r_active_mask  <= r_shadow_mask;
                r_active_blink <= r_shadow_blink;
            end
        end
    end

    // Frame counter toggles the blink phase every BLINK_FRAMES frames
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (bus.frameStart) begin
            if (r_frame_cnt == FRAME_LAST) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt   <= r_frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

    // Stage 1: register colours and the fully qualified show bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_color <= '0;
            r_s1_show  <= '0;
            r_s1_de    <= 1'b0;
            r_s1_bg    <= '0;
        end else begin
            r_s1_color <= bus.layerColor;
            r_s1_show  <= bus.layerShow & r_active_mask & w_blink_gate;
            r_s1_de    <= bus.displayEnable;
            r_s1_bg    <= bus.bgColor;
        end
    end

    priority_select #(
        .NUM_LAYERS (NUM_LAYERS),
        .COLOR_W    (COLOR_W)
    ) u_priority_select (
        .i_show    (r_s1_show),
        .i_colors  (r_s1_color),
        .o_index   (w_sel_index),
        .o_color   (w_sel_color),
        .o_any     (w_sel_any),
        .o_overlap (w_sel_overlap)
    );

    // Stage 2: winning layer, background, or black during blanking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_color <= '0;
            r_valid <= 1'b0;
            r_hit   <= BG_INDEX;
        end else begin
            r_valid <= r_s1_de;
            if (!r_s1_de) begin
                r_color <= '0;
                r_hit   <= BG_INDEX;
            end else if (w_sel_any) begin
                r_color <= w_sel_color;
                r_hit   <= w_sel_index;
            end else begin
                r_color <= r_s1_bg;
                r_hit   <= BG_INDEX;
            end
        end
    end

    // Sticky per-frame overlap record; a detection on the frameStart cycle beats the clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overlap <= '0;
        end else if (r_s1_de && w_sel_overlap) begin
            r_overlap <= (bus.frameStart ? '0 : r_overlap) | r_s1_show;
        end else if (bus.frameStart) begin
            r_overlap <= '0;
        end
    end

    assign bus.color       = r_color;
    assign bus.colorValid  = r_valid;
    assign bus.hitLayer    = r_hit;
    assign bus.overlapMask = r_overlap;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: stimulus pushes expected pixels into a
// queue, an independent monitor pops and compares on every valid output.
module tb_layer_compositor;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q[$];     // {hitLayer, color}
    logic [10:0] mon_got;
    logic [10:0] mon_exp;
    logic [5:0]  blink_vis;
    logic [31:0] cols;

    layer_compositor_if #(.NUM_LAYERS(4), .COLOR_W(8)) bus ();

    layer_compositor #(
        .NUM_LAYERS   (4),
        .COLOR_W      (8),
        .BLINK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor / scoreboard: every valid output must match the oldest expectation
    always @(negedge clk) begin
        if (bus.colorValid === 1'b1) begin
            checks++;
            mon_got = {bus.hitLayer, bus.color};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got hit %0d color 0x%0h, no pixel pending",
                         bus.hitLayer, bus.color);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL out_pixel: got hit %0d color 0x%0h, expected hit %0d color 0x%0h",
                             mon_got[10:8], mon_got[7:0], mon_exp[10:8], mon_exp[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.frameStart = 1'b0;
        bus.cfgWrite   = 1'b0;
    endtask

    task automatic pix(input logic de, input logic [3:0] show);
        bus.displayEnable = de;
        bus.layerShow     = show;
    endtask

    task automatic exp_push(input logic [2:0] hit, input logic [7:0] color);
        exp_q.push_back({hit, color});
    endtask

    // Stimulus. Layer colours: L0=E0 L1=55 L2=1C L3=AA
    initial begin
        cols              = 32'hAA_1C_55_E0;
        rst_n             = 1'b0;
        bus.displayEnable = 1'b0;
        bus.frameStart    = 1'b0;
        bus.layerColor    = cols;
        bus.layerShow     = '0;
        bus.maskIn        = 4'hF;
        bus.blinkIn       = 4'h0;
        bus.cfgWrite      = 1'b0;
        bus.bgColor       = 8'h03;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_color", {24'd0, bus.color}, 32'h00);
        chk("rst_valid", {31'd0, bus.colorValid}, 32'd0);
        chk("rst_hit", {29'd0, bus.hitLayer}, 32'd7);
        chk("rst_overlap", {28'd0, bus.overlapMask}, 32'h0);
        rst_n = 1'b1;
        tick(); tick();

        // Priority: layers 0 and 2, exactly two cycles of latency
        pix(1, 4'b0101); exp_push(3'd0, 8'hE0); tick();
        pix(0, 4'b0000);
        @(negedge clk);
        chk("lat_cycle1_valid", {31'd0, bus.colorValid}, 32'd0);
        tick();
        @(negedge clk);
        chk("lat_cycle2_valid", {31'd0, bus.colorValid}, 32'd1);
        chk("prio_color", {24'd0, bus.color}, 32'hE0);
        chk("prio_hit", {29'd0, bus.hitLayer}, 32'd0);
        chk("prio_overlap", {28'd0, bus.overlapMask}, 32'b0101);

        // Back-to-back pixels, background and blanking
        pix(1, 4'b1110); exp_push(3'd1, 8'h55); tick();
        pix(1, 4'b1000); exp_push(3'd3, 8'hAA); tick();
        pix(1, 4'b1111); exp_push(3'd0, 8'hE0); tick();
        pix(1, 4'b0000); exp_push(3'd7, 8'h03); tick();
        bus.bgColor = 8'h5A;
        pix(1, 4'b0000); exp_push(3'd7, 8'h5A); tick();
        bus.bgColor = 8'h03;
        pix(0, 4'b0101); tick();
        pix(0, 4'b0000); tick();
        @(negedge clk);
        chk("blank_color", {24'd0, bus.color}, 32'h00);
        chk("blank_hit", {29'd0, bus.hitLayer}, 32'd7);
        chk("blank_valid", {31'd0, bus.colorValid}, 32'd0);

        // Mask timing: mid-frame cfgWrite only takes effect next frame
        bus.frameStart = 1'b1; pix(0, 4'b0000); tick(); tick(); tick();
        pix(1, 4'b0011); exp_push(3'd0, 8'hE0); tick();
        bus.maskIn = 4'b1110; bus.cfgWrite = 1'b1;
        pix(1, 4'b0011); exp_push(3'd0, 8'hE0); tick();
        pix(1, 4'b0011); exp_push(3'd0, 8'hE0); tick();
        pix(0, 4'b0000); tick(); tick();
        pix(1, 4'b0011); exp_push(3'd0, 8'hE0); tick();
        bus.frameStart = 1'b1; pix(0, 4'b0000); tick(); tick(); tick();
        pix(1, 4'b0011); exp_push(3'd1, 8'h55); tick();
        pix(1, 4'b0001); exp_push(3'd7, 8'h03); tick();
        // cfgWrite coincident with frameStart applies to the new frame
        pix(0, 4'b0000); bus.maskIn = 4'hF; bus.cfgWrite = 1'b1; bus.frameStart = 1'b1;
        tick(); tick(); tick();
        pix(1, 4'b0011); exp_push(3'd0, 8'hE0); tick();

        // Overlap record and its frame clear
        pix(0, 4'b0000); tick();
        bus.frameStart = 1'b1; tick(); tick();
        @(negedge clk);
        chk("ovl_cleared", {28'd0, bus.overlapMask}, 32'h0);
        pix(0, 4'b1111); tick();
        pix(1, 4'b0100); exp_push(3'd2, 8'h1C); tick();
        pix(0, 4'b0000); tick(); tick();
        @(negedge clk);
        chk("ovl_none", {28'd0, bus.overlapMask}, 32'h0);
        pix(1, 4'b0110); exp_push(3'd1, 8'h55); tick();
        pix(0, 4'b0000); bus.frameStart = 1'b1; tick();
        @(negedge clk);
        chk("ovl_on_fs", {28'd0, bus.overlapMask}, 32'b0110);
        tick();
        bus.frameStart = 1'b1; tick();
        @(negedge clk);
        chk("ovl_after_fs", {28'd0, bus.overlapMask}, 32'h0);

        // Reset while streaming
        pix(1, 4'b0110); exp_push(3'd1, 8'h55); tick();
        pix(1, 4'b1000); exp_push(3'd3, 8'hAA); tick();
        pix(1, 4'b0100); tick();
        rst_n = 1'b0; pix(1, 4'b0001); tick();
        rst_n = 1'b1; pix(1, 4'b0100); exp_push(3'd2, 8'h1C);
        @(negedge clk);
        chk("mrst_color", {24'd0, bus.color}, 32'h00);
        chk("mrst_valid", {31'd0, bus.colorValid}, 32'd0);
        chk("mrst_hit", {29'd0, bus.hitLayer}, 32'd7);
        chk("mrst_overlap", {28'd0, bus.overlapMask}, 32'h0);
        tick();
        pix(1, 4'b0001); exp_push(3'd0, 8'hE0);
        @(negedge clk);
        chk("mrst_rel1_valid", {31'd0, bus.colorValid}, 32'd0);
        tick();
        pix(0, 4'b0000);
        @(negedge clk);
        chk("mrst_rel2_valid", {31'd0, bus.colorValid}, 32'd1);
        chk("mrst_rel2_color", {24'd0, bus.color}, 32'h1C);
        tick(); tick();

        // Blink on layer 0 with 2 frames per half-period (frame counter fresh from reset)
        blink_vis = 6'b011001;
        bus.blinkIn = 4'b0001; bus.maskIn = 4'hF; bus.cfgWrite = 1'b1;
        pix(0, 4'b0000); tick();
        for (int f = 0; f < 6; f++) begin
            bus.frameStart = 1'b1; pix(0, 4'b0000); tick(); tick(); tick();
            pix(1, 4'b0011);
            if (blink_vis[f]) exp_push(3'd0, 8'hE0);
            else              exp_push(3'd1, 8'h55);
            tick();
        end

        pix(0, 4'b0000);
        repeat (4) tick();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
